// File: rtl/segway_math_pipe_pkg.sv
// Shared constants and helpers for the Segway balance math pipeline.
//   - steer pot clip window, centre and scaling (x*3 >>> 4)
//   - soft-start timer ceiling
//   - saturate(): clamp an integer to a signed field of a given width
package segway_pkg;

    localparam logic [11:0] STEER_MIN   = 12'h200;
    localparam logic [11:0] STEER_MAX   = 12'hE00;
    localparam int          STEER_CTR   = 'h7FF;
    localparam int          STEER_MULT  = 3;
    localparam int          STEER_SHIFT = 4;
    // (0xE00-0x7FF)*3 >>> 4 = 288 and (0x200-0x7FF)*3 >>> 4 = -288 fit in 10 signed bits
    localparam int          STEER_W     = 10;

    localparam logic [7:0]  SS_MAX      = 8'd255;

    // Clamp value into the range of a signed two's-complement field of 'width' bits.
    function automatic int saturate(input int value, input int width);
        int hi;
        int lo;
        int res;
        hi  = (1 << (width - 1)) - 1;
        lo  = -(1 << (width - 1));
        res = value;
        if (value > hi) begin
            res = hi;
        end else if (value < lo) begin
            res = lo;
        end
        return res;
    endfunction

endpackage

// File: rtl/segway_math_pipe_if.sv
// Sample/result bundle between the PID controller, the math pipeline and the
// motor drive.
//   master : drives vld_in, PID_cntrl, steer_pot, en_steer, pwr_up;
//            receives lft_spd, rght_spd, vld_out, too_fast, ss_done
//   slave  : the math pipeline (opposite directions)
interface segway_math_pipe_if #(
    parameter int CTRL_W = 12,
    parameter int SPD_W  = 12
);
    logic                     vld_in;
    logic signed [CTRL_W-1:0] PID_cntrl;
    logic        [11:0]       steer_pot;
    logic                     en_steer;
    logic                     pwr_up;
    logic signed [SPD_W-1:0]  lft_spd;
    logic signed [SPD_W-1:0]  rght_spd;
    logic                     vld_out;
    logic                     too_fast;
    logic                     ss_done;

    modport master (
        output vld_in, PID_cntrl, steer_pot, en_steer, pwr_up,
        input  lft_spd, rght_spd, vld_out, too_fast, ss_done
    );

    modport slave (
        input  vld_in, PID_cntrl, steer_pot, en_steer, pwr_up,
        output lft_spd, rght_spd, vld_out, too_fast, ss_done
    );
endinterface

// File: rtl/segway_math_pipe_shape.sv
// Combinational deadzone shaping for one motor side.
//   t      : signed torque request (PID plus/minus steer)
//   pwr    : drive enabled; 0 forces the output to zero
//   shaped : |t| >= LOW_TORQUE_BAND -> t +/- MIN_DUTY, else t*GAIN_MULT
//            (unsaturated, wide enough for any shaped value)
module segway_shape #(
    parameter int T_W             = 14,
    parameter int SH_W            = 16,
    parameter int MIN_DUTY        = 960,
    parameter int LOW_TORQUE_BAND = 60,
    parameter int GAIN_MULT       = 4
) (
    input  logic signed [T_W-1:0]  t,
    input  logic                   pwr,
    output logic signed [SH_W-1:0] shaped
);

    int tv;
    int res;

    always_comb begin
        // NOTE: every combinational output gets a default first so no branch leaves it unassigned and infers a latch.
        tv  = int'(t);
        res = 0;
        if (!pwr) begin
            res = 0;
        end else if (tv >= LOW_TORQUE_BAND) begin
            res = tv + MIN_DUTY;
        end else if (tv <= -LOW_TORQUE_BAND) begin
            res = tv - MIN_DUTY;
        end else begin
            // low band is boosted instead of offset; zero stays zero
            res = tv * GAIN_MULT;
        end
        shaped = SH_W'(res);
    end

endmodule

// File: rtl/segway_math_pipe.sv
// Three-stage pipelined Segway balance math.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : slave side of segway_math_pipe_if
//     in : vld_in, PID_cntrl, steer_pot, en_steer, pwr_up
//     out: lft_spd, rght_spd (saturated, registered), vld_out,
//          too_fast (debounced overspeed), ss_done (soft start complete)
// Stage 1 scales PID by the soft-start timer and derives steer, stage 2 mixes
// and shapes each side, stage 3 saturates into the output registers.
module segway_math_pipe
    import segway_pkg::*;
#(
    parameter int CTRL_W          = 12,
    parameter int SPD_W           = 12,
    parameter int MIN_DUTY        = 960,
    parameter int LOW_TORQUE_BAND = 60,
    parameter int GAIN_MULT       = 4,
    parameter int FAST_THRESH     = 1536,
    parameter int FAST_CNT        = 4,
    parameter int SS_DIV          = 4
) (
    input logic                clk,
    input logic                rst_n,
    segway_math_pipe_if.slave  bus
);

    localparam int T_W   = CTRL_W + 2;
    localparam int SH_W  = T_W + 2;
    localparam int DIV_W = (SS_DIV > 1) ? $clog2(SS_DIV) : 1;
    localparam int CNT_W = $clog2(FAST_CNT + 1);

    // ---------------- soft start ----------------
    logic [7:0]       ss_tmr, ss_tmr_nxt;
    logic [DIV_W-1:0] ss_div, ss_div_nxt;

    always_comb begin
        ss_tmr_nxt = ss_tmr;
        ss_div_nxt = ss_div;
        if (!bus.pwr_up) begin
            ss_tmr_nxt = '0;
            ss_div_nxt = '0;
        end else if (ss_tmr != SS_MAX) begin
            if (ss_div == DIV_W'(SS_DIV - 1)) begin
                ss_div_nxt = '0;
                ss_tmr_nxt = ss_tmr + 8'd1;
            end else begin
                ss_div_nxt = ss_div + DIV_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: non-blocking assignments so every register samples pre-edge values regardless of statement order.
        if (!rst_n) begin
            ss_tmr      <= '0;
            ss_div      <= '0;
            bus.ss_done <= 1'b0;
        end else begin
            ss_tmr      <= ss_tmr_nxt;
            ss_div      <= ss_div_nxt;
            // taken from the next timer value so ss_done lines up with ss_tmr
            bus.ss_done <= (ss_tmr_nxt == SS_MAX);
        end
    end

    // ---------------- stage 1: soft-start scaling and steer ----------------
    logic        [11:0]        pot_clip;
    int                        steer_x;
    logic signed [STEER_W-1:0] steer_d;
    logic signed [CTRL_W-1:0]  pid_ss_d;

    always_comb begin
        pot_clip = bus.steer_pot;
        if (bus.steer_pot < STEER_MIN) begin
            pot_clip = STEER_MIN;
        end else if (bus.steer_pot > STEER_MAX) begin
            pot_clip = STEER_MAX;
        end
        steer_x  = int'(pot_clip) - STEER_CTR;
        // int is signed, so >>> floors toward -inf
        steer_d  = STEER_W'((steer_x * STEER_MULT) >>> STEER_SHIFT);
        pid_ss_d = CTRL_W'((int'(bus.PID_cntrl) * int'(ss_tmr)) >>> 8);
    end

    logic                      vld1;
    logic signed [CTRL_W-1:0]  pid_ss1;
    logic signed [STEER_W-1:0] steer1;
    logic                      en1;
    logic                      pwr1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld1    <= 1'b0;
            pid_ss1 <= '0;
            steer1  <= '0;
            en1     <= 1'b0;
            pwr1    <= 1'b0;
        end else begin
            vld1 <= bus.vld_in;
            if (bus.vld_in) begin
                pid_ss1 <= pid_ss_d;
                steer1  <= steer_d;
                en1     <= bus.en_steer;
                pwr1    <= bus.pwr_up;
            end
        end
    end

    // ---------------- stage 2: mix and shape ----------------
    logic signed [STEER_W-1:0] steer_eff;
    logic signed [T_W-1:0]     lft_t, rght_t;
    logic signed [SH_W-1:0]    lft_sh_d, rght_sh_d;

    always_comb begin
        steer_eff = en1 ? steer1 : '0;
        lft_t     = T_W'(int'(pid_ss1) + int'(steer_eff));
        rght_t    = T_W'(int'(pid_ss1) - int'(steer_eff));
    end

    segway_shape #(
        .T_W(T_W), .SH_W(SH_W), .MIN_DUTY(MIN_DUTY),
        .LOW_TORQUE_BAND(LOW_TORQUE_BAND), .GAIN_MULT(GAIN_MULT)
    ) u_shape_lft (
        .t(lft_t), .pwr(pwr1), .shaped(lft_sh_d)
    );

    segway_shape #(
        .T_W(T_W), .SH_W(SH_W), .MIN_DUTY(MIN_DUTY),
        .LOW_TORQUE_BAND(LOW_TORQUE_BAND), .GAIN_MULT(GAIN_MULT)
    ) u_shape_rght (
        .t(rght_t), .pwr(pwr1), .shaped(rght_sh_d)
    );

    logic                   vld2;
    logic signed [SH_W-1:0] lft_sh2, rght_sh2;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld2     <= 1'b0;
            lft_sh2  <= '0;
            rght_sh2 <= '0;
        end else begin
            vld2 <= vld1;
            if (vld1) begin
                lft_sh2  <= lft_sh_d;
                rght_sh2 <= rght_sh_d;
            end
        end
    end

    // ---------------- stage 3: saturate into outputs ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.vld_out  <= 1'b0;
            bus.lft_spd  <= '0;
            bus.rght_spd <= '0;
        end else begin
            bus.vld_out <= vld2;
            if (vld2) begin
                bus.lft_spd  <= SPD_W'(saturate(int'(lft_sh2), SPD_W));
                bus.rght_spd <= SPD_W'(saturate(int'(rght_sh2), SPD_W));
            end
        end
    end

    // ---------------- too_fast debounce ----------------
    logic             fast;
    logic [CNT_W-1:0] fast_cnt, fast_cnt_nxt;

    always_comb begin
        // signed compare: reverse speeds never count as fast
        fast         = (int'(bus.lft_spd) > FAST_THRESH) || (int'(bus.rght_spd) > FAST_THRESH);
        fast_cnt_nxt = fast_cnt;
        if (!fast) begin
            fast_cnt_nxt = '0;
        end else if (fast_cnt != CNT_W'(FAST_CNT)) begin
            fast_cnt_nxt = fast_cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fast_cnt     <= '0;
            bus.too_fast <= 1'b0;
        end else if (bus.vld_out) begin
            fast_cnt     <= fast_cnt_nxt;
            bus.too_fast <= (fast_cnt_nxt == CNT_W'(FAST_CNT));
        end
    end

endmodule

// File: doc/segway_math_pipe.md
Name: segway_math_pipe

Overview:
- Parametrised, pipelined successor to the combinational Segway balance math.
- Takes the PID output and the steering pot reading, then applies the following, producing registered left/right motor speeds with a valid strobe:
  - internal soft-start scaling
  - steer mixing
  - deadzone shaping
  - saturation
  - a debounced too_fast flag
- Sits between the PID controller and the motor PWM/drive block.

Parameters:
- CTRL_W, 12: signed width of PID_cntrl.
- SPD_W, 12: signed width of lft_spd/rght_spd; CTRL_W <= SPD_W.
- MIN_DUTY, 960 (0x3C0): torque offset added outside the low band.
- LOW_TORQUE_BAND, 60 (0x3C): magnitude threshold for the deadzone region.
- GAIN_MULT, 4: gain applied inside the low band.
- FAST_THRESH, 1536: speed above which a sample counts as fast.
- FAST_CNT, 4: consecutive fast valid samples required to assert too_fast.
- SS_DIV, 4: clocks per soft-start timer increment.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- vld_in  in  1  new PID/steer sample present this cycle.
- PID_cntrl  in  CTRL_W  signed PID output.
- steer_pot  in  12  unsigned steering potentiometer.
- en_steer  in  1  enable steer mixing.
- pwr_up  in  1  rider present / drive enabled.
- lft_spd  out  SPD_W  signed left motor speed.
- rght_spd  out  SPD_W  signed right motor speed.
- vld_out  out  1  lft_spd/rght_spd updated this cycle.
- too_fast  out  1  debounced overspeed flag.
- ss_done  out  1  soft-start timer saturated.

Behaviour:
- Reset: all pipeline registers, lft_spd, rght_spd, vld_out, too_fast, ss_done, ss_tmr and the fast counter go to 0.
- Soft start (free-running, independent of vld_in):
  - 8-bit ss_tmr plus a divider counter.
  - While pwr_up=1 and ss_tmr<255: ss_tmr increments once every SS_DIV clocks.
  - ss_tmr saturates at 255.
  - pwr_up=0 clears ss_tmr and the divider on the next edge.
  - ss_done = (ss_tmr==255), registered.
- Stage 1 (captured when vld_in=1; PID_cntrl, en_steer and pwr_up are registered alongside):
  - PID_ss = (PID_cntrl * signed{0,ss_tmr}) >>> 8, truncated to CTRL_W; arithmetic shift, floor toward -inf.
  - Steer path:
    - clip steer_pot to [0x200, 0xE00];
    - subtract 0x7FF giving signed 13 bits;
    - steer = (x*3) >>> 4;
    - steer = 0 when en_steer=0.
- Stage 2:
  - lft_t = PID_ss + steer; rght_t = PID_ss - steer; computed at CTRL_W+2 bits, no overflow.
  - Shaping per side:
    - |t| >= LOW_TORQUE_BAND: t>0 gives t+MIN_DUTY; t<0 gives t-MIN_DUTY.
    - Otherwise: t*GAIN_MULT.
    - Zero stays zero.
  - Shaped result forced to 0 when the staged pwr_up=0.
- Stage 3:
  - Saturate each side to signed SPD_W: max 2^(SPD_W-1)-1, min -2^(SPD_W-1).
  - Register into lft_spd/rght_spd.
- Latency and valid:
  - Valid bits shift with the data; vld_out rises exactly 3 clocks after the vld_in edge.
  - Back-to-back vld_in gives one result per clock.
  - Stages not holding valid data do not update their registers; outputs hold their last value.
- too_fast, updated only on cycles with vld_out=1 (signed compare; negative speeds are never fast):
  - Sample is fast when lft_spd>FAST_THRESH or rght_spd>FAST_THRESH.
  - Fast sample: increment the counter, saturating at FAST_CNT.
  - Non-fast sample: clear the counter.
  - too_fast = (counter==FAST_CNT), registered one clock after the qualifying vld_out.
- Asynchronous reset mid-operation: in-flight samples are discarded and no vld_out is produced for them.

Decomposition:
- Package segway_pkg holds:
  - steer clip limits 0x200/0xE00;
  - steer centre 0x7FF;
  - steer scale constants 3 and 4;
  - soft-start maximum 255;
  - a saturate function (value, width).
- One sub-module, segway_shape, is natural: combinational deadzone shaping plus pwr_up zeroing, instantiated twice (left and right).

Test Plan:
- Soft start: reset, then pwr_up=1 and SS_DIV=4 -> ss_done rises 1020 clocks later (±1); dropping pwr_up -> ss_tmr=0 and ss_done=0 the next cycle.
- Forward drive: ss_tmr=255, en_steer=0, PID_cntrl=0x3FF, vld_in pulse -> 3 clocks later vld_out=1, lft_spd=rght_spd=1979.
- Low band: ss_tmr=255, PID_cntrl=32 -> both speeds 124; PID_cntrl=-32 -> both speeds -128.
- Steer: PID_cntrl=0, en_steer=1, steer_pot=0xFFF -> lft_spd=1248, rght_spd=-1248; en_steer=0 -> both 0.
- Saturation plus too_fast: PID_cntrl=0x7FF, ss_tmr=255, four consecutive valids -> speeds 2047; too_fast=1 after the 4th vld_out; one sample with PID_cntrl=0 -> too_fast=0.
- Power down and reset: pwr_up=0 with any input -> speeds 0. Asserting rst_n low while 3 samples are in flight -> outputs 0 immediately and no vld_out afterwards.
